// File: rtl/laser_paint_pkg.sv
// Shared types and helpers for the laser-paint drawing path.
//   coord_t        : raw 11-bit laser coordinate from Detection
//   pix_t          : 10-bit framebuffer coordinate
//   err_t          : signed Bresenham error / delta term
//   stroke_state_t : stroke interpolator FSM states
//   bres_pos_t     : current pixel plus error term of a line walk
//   abs_diff       : |a - b| widened to err_t
//   bres_step      : one Bresenham step
package laser_paint_pkg;

    typedef logic [10:0]        coord_t;
    typedef logic [9:0]         pix_t;
    typedef logic signed [12:0] err_t;

    typedef enum logic [1:0] {IDLE, SETUP, DRAW} stroke_state_t;

    localparam int H_RES_DEFAULT    = 640;
    localparam int V_RES_DEFAULT    = 480;
    localparam int MAX_JUMP_DEFAULT = 64;

    typedef struct packed {
        pix_t x;
        pix_t y;
        err_t err;
    } bres_pos_t;

    function automatic err_t abs_diff(input pix_t a, input pix_t b);
        pix_t d;
        d = (a >= b) ? (a - b) : (b - a);
        return err_t'({3'b000, d});
    endfunction

    // e2 = 2*err; the two tests use the error from before this step.
    function automatic bres_pos_t bres_step(input bres_pos_t p,
                                            input err_t      dx,
                                            input err_t      dy,
                                            input logic      sx_neg,
                                            input logic      sy_neg);
        bres_pos_t n;
        err_t      e2;
        n  = p;
        e2 = p.err <<< 1;
        if (e2 > -dy) begin
            n.err = n.err - dy;
            n.x   = sx_neg ? (p.x - 10'd1) : (p.x + 10'd1);
        end
        if (e2 < dx) begin
            n.err = n.err + dx;
            n.y   = sy_neg ? (p.y - 10'd1) : (p.y + 10'd1);
        end
        return n;
    endfunction

endpackage

// File: rtl/line_stepper.sv
// Bresenham line walker. Pure arithmetic, no handshake logic.
// Ports:
//   clk, srst      : clock, synchronous active-high reset
//   load           : capture a new line from (x0,y0) to (x1,y1)
//   skip_first     : on load, take one step immediately so the start
//                    point itself is never presented
//   x0, y0, x1, y1 : line start / end
//   step           : advance one pixel (ignored once done)
//   x, y           : current pixel
//   done           : current pixel is the endpoint
module line_stepper
    import laser_paint_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic       load,
    input  logic       skip_first,
    input  logic [9:0] x0,
    input  logic [9:0] y0,
    input  logic [9:0] x1,
    input  logic [9:0] y1,
    input  logic       step,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       done
);

    pix_t x_reg, y_reg, x1_reg, y1_reg;
    err_t err_reg, dx_reg, dy_reg;
    logic sx_neg_reg, sy_neg_reg;

    err_t      ld_dx, ld_dy;
    logic      ld_sx_neg, ld_sy_neg;
    bres_pos_t ld_pos, ld_first, step_pos;

    always_comb begin
        ld_dx     = abs_diff(x1, x0);
        ld_dy     = abs_diff(y1, y0);
        ld_sx_neg = (x1 < x0);
        ld_sy_neg = (y1 < y0);
        ld_pos    = '{x: x0, y: y0, err: ld_dx - ld_dy};
        ld_first  = skip_first ? bres_step(ld_pos, ld_dx, ld_dy, ld_sx_neg, ld_sy_neg)
                               : ld_pos;
        step_pos  = bres_step('{x: x_reg, y: y_reg, err: err_reg},
                              dx_reg, dy_reg, sx_neg_reg, sy_neg_reg);
    end

    assign done = (x_reg == x1_reg) && (y_reg == y1_reg);
    assign x    = x_reg;
    assign y    = y_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            x_reg      <= '0;
            y_reg      <= '0;
            x1_reg     <= '0;
            y1_reg     <= '0;
            err_reg    <= '0;
            dx_reg     <= '0;
            dy_reg     <= '0;
            sx_neg_reg <= 1'b0;
            sy_neg_reg <= 1'b0;
        end else if (load) begin
            x_reg      <= ld_first.x;
            y_reg      <= ld_first.y;
            err_reg    <= ld_first.err;
            x1_reg     <= x1;
            y1_reg     <= y1;
            dx_reg     <= ld_dx;
            dy_reg     <= ld_dy;
            sx_neg_reg <= ld_sx_neg;
            sy_neg_reg <= ld_sy_neg;
        end else if (step && !done) begin
            x_reg   <= step_pos.x;
            y_reg   <= step_pos.y;
            err_reg <= step_pos.err;
        end
    end

endmodule

// File: rtl/stroke_interpolator.sv
// Turns sparse per-frame laser samples into continuous framebuffer strokes.
// Each accepted sample is joined to the previous drawn point (anchor) with a
// Bresenham line, or starts a new stroke when it is too far away, the anchor
// is unknown, or the pen was up.
// Ports:
//   Clk, Reset        : clock, synchronous active-high reset
//   sample_valid      : one-cycle pulse with sample_x/sample_y/pen_down
//   wr_valid/wr_ready : pixel write handshake, wr_x/wr_y held while stalled
//   stroke_start      : first pixel of a new stroke
//   busy              : FSM not idle
//   drop_count        : saturating count of overwritten pending samples
module stroke_interpolator
    import laser_paint_pkg::*;
#(
    parameter int H_RES    = H_RES_DEFAULT,
    parameter int V_RES    = V_RES_DEFAULT,
    parameter int MAX_JUMP = MAX_JUMP_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        sample_valid,
    input  logic [10:0] sample_x,
    input  logic [10:0] sample_y,
    input  logic        pen_down,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [9:0]  wr_x,
    output logic [9:0]  wr_y,
    output logic        stroke_start,
    output logic        busy,
    output logic [7:0]  drop_count
);

    localparam coord_t H_LIMIT    = coord_t'(H_RES);
    localparam coord_t V_LIMIT    = coord_t'(V_RES);
    localparam err_t   JUMP_LIMIT = err_t'(MAX_JUMP);

    stroke_state_t state_reg, state_next;

    logic   anchor_valid_reg;
    pix_t   anchor_x_reg, anchor_y_reg;
    logic   pend_valid_reg, pend_pen_reg;
    coord_t pend_x_reg, pend_y_reg;
    logic   cur_pen_reg;
    coord_t cur_x_reg, cur_y_reg;
    logic [7:0] drop_count_reg;
    logic   wr_valid_reg, stroke_start_reg;

    // Classification of the sample held in cur_*; only meaningful in SETUP.
    pix_t cur_px, cur_py;
    err_t jump_dx, jump_dy;
    logic cur_in_range, is_jump, is_same, need_write;

    always_comb begin
        cur_px       = cur_x_reg[9:0];
        cur_py       = cur_y_reg[9:0];
        cur_in_range = cur_pen_reg && (cur_x_reg < H_LIMIT) && (cur_y_reg < V_LIMIT);
        jump_dx      = abs_diff(cur_px, anchor_x_reg);
        jump_dy      = abs_diff(cur_py, anchor_y_reg);
        is_jump      = !anchor_valid_reg || (jump_dx > JUMP_LIMIT) || (jump_dy > JUMP_LIMIT);
        is_same      = (cur_px == anchor_x_reg) && (cur_py == anchor_y_reg);
        need_write   = cur_in_range && (is_jump || !is_same);
    end

    // Stepper: a new stroke is a degenerate line from the sample to itself;
    // a joined line starts at the anchor, which is stepped past on load.
    logic step_done, step_load, step_adv;
    pix_t step_x, step_y;

    assign step_load = (state_reg == SETUP) && need_write;
    assign step_adv  = (state_reg == DRAW) && wr_ready;

    line_stepper u_line_stepper (
        .clk        (Clk),
        .srst       (Reset),
        .load       (step_load),
        .skip_first (!is_jump),
        .x0         (is_jump ? cur_px : anchor_x_reg),
        .y0         (is_jump ? cur_py : anchor_y_reg),
        .x1         (cur_px),
        .y1         (cur_py),
        .step       (step_adv),
        .x          (step_x),
        .y          (step_y),
        .done       (step_done)
    );

    // Sequencing. Leaving DRAW (or a SETUP with nothing to draw) goes straight
    // back to SETUP when a pending sample is waiting. A sample arriving in the
    // same cycle the pending slot is emptied refills it without a drop.
    logic leaving, consume_pend, take_sample, go_setup, store_pend, drop_now;

    always_comb begin
        leaving      = ((state_reg == DRAW) && wr_ready && step_done)
                    || ((state_reg == SETUP) && !need_write);
        consume_pend = pend_valid_reg && ((state_reg == IDLE) || leaving);
        take_sample  = (state_reg == IDLE) && sample_valid && !pend_valid_reg;
        go_setup     = consume_pend || take_sample;
        store_pend   = sample_valid && !take_sample;
        drop_now     = store_pend && pend_valid_reg && !consume_pend;

        state_next = state_reg;
        if (go_setup)
            state_next = SETUP;
        else if (leaving)
            state_next = IDLE;
        else if (state_reg == SETUP)
            state_next = DRAW;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg        <= IDLE;
            anchor_valid_reg <= 1'b0;
            anchor_x_reg     <= '0;
            anchor_y_reg     <= '0;
            pend_valid_reg   <= 1'b0;
            pend_pen_reg     <= 1'b0;
            pend_x_reg       <= '0;
            pend_y_reg       <= '0;
            cur_pen_reg      <= 1'b0;
            cur_x_reg        <= '0;
            cur_y_reg        <= '0;
            drop_count_reg   <= '0;
            wr_valid_reg     <= 1'b0;
            stroke_start_reg <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (store_pend) begin
                pend_valid_reg <= 1'b1;
                pend_x_reg     <= sample_x;
                pend_y_reg     <= sample_y;
                pend_pen_reg   <= pen_down;
            end else if (consume_pend) begin
                pend_valid_reg <= 1'b0;
            end

            if (drop_now && (drop_count_reg != 8'hFF))
                drop_count_reg <= drop_count_reg + 8'd1;

            if (go_setup) begin
                cur_x_reg   <= consume_pend ? pend_x_reg   : sample_x;
                cur_y_reg   <= consume_pend ? pend_y_reg   : sample_y;
                cur_pen_reg <= consume_pend ? pend_pen_reg : pen_down;
            end

            // Anchor follows the sample as soon as its writes are committed;
            // an unusable sample breaks the stroke.
            if (state_reg == SETUP) begin
                if (!cur_in_range) begin
                    anchor_valid_reg <= 1'b0;
                end else if (need_write) begin
                    anchor_valid_reg <= 1'b1;
                    anchor_x_reg     <= cur_px;
                    anchor_y_reg     <= cur_py;
                end
            end

            wr_valid_reg <= (state_next == DRAW);

            if (state_reg == SETUP)
                stroke_start_reg <= need_write && is_jump;
            else if (state_next != DRAW)
                stroke_start_reg <= 1'b0;
        end
    end

    assign wr_valid     = wr_valid_reg;
    assign wr_x         = step_x;
    assign wr_y         = step_y;
    assign stroke_start = stroke_start_reg;
    assign busy         = (state_reg != IDLE);
    assign drop_count   = drop_count_reg;

endmodule

// File: tb/tb_stroke_interpolator.sv
// Directed bench for stroke_interpolator: a vector table of samples with
// hand-computed pixel sequences, plus hand-written stall, pending and
// mid-line reset sequences.
module tb_stroke_interpolator;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        sample_valid;
    logic [10:0] sample_x, sample_y;
    logic        pen_down;
    logic        wr_valid, wr_ready;
    logic [9:0]  wr_x, wr_y;
    logic        stroke_start, busy;
    logic [7:0]  drop_count;

    stroke_interpolator dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .sample_valid (sample_valid),
        .sample_x     (sample_x),
        .sample_y     (sample_y),
        .pen_down     (pen_down),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_x         (wr_x),
        .wr_y         (wr_y),
        .stroke_start (stroke_start),
        .busy         (busy),
        .drop_count   (drop_count)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_err = 0;

    int cap_px[$];
    int cap_ss[$];
    int cap_off[$];

    typedef struct {
        int x;
        int y;
        bit pen;
        int n;
        int p0, p1, p2, p3;
        int last;
        bit ss;
    } vec_t;

    vec_t vecs[17];

    function automatic int P(input int x, input int y);
        return x * 10000 + y;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called #1 after an edge; returns #1 after the edge that captured it.
    task automatic send(input int x, input int y, input bit pen);
        sample_x     = 11'(x);
        sample_y     = 11'(y);
        pen_down     = pen;
        sample_valid = 1'b1;
        @(posedge Clk); #1;
        sample_valid = 1'b0;
    endtask

    // Records every handshake with its cycle offset until busy falls.
    task automatic collect(input int max_cyc, output int timed_out);
        cap_px.delete();
        cap_ss.delete();
        cap_off.delete();
        timed_out = 1;
        for (int c = 0; c < max_cyc; c++) begin
            if (!busy) begin
                timed_out = 0;
                break;
            end
            if (wr_valid && wr_ready) begin
                cap_px.push_back(P(int'(wr_x), int'(wr_y)));
                cap_ss.push_back(int'(stroke_start));
                cap_off.push_back(c);
            end
            @(posedge Clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int to;
        int n;
        vec_t v;

        vecs[0]  = '{100, 50, 1, 1, P(100,50), 0, 0, 0, P(100,50), 1};
        vecs[1]  = '{104, 52, 1, 4, P(101,50), P(102,51), P(103,51), P(104,52), P(104,52), 0};
        vecs[2]  = '{300, 200, 1, 1, P(300,200), 0, 0, 0, P(300,200), 1};
        vecs[3]  = '{700, 10, 1, 0, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{104, 52, 1, 1, P(104,52), 0, 0, 0, P(104,52), 1};
        vecs[5]  = '{106, 52, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[6]  = '{105, 52, 1, 1, P(105,52), 0, 0, 0, P(105,52), 1};
        vecs[7]  = '{105, 52, 1, 0, 0, 0, 0, 0, 0, 0};
        vecs[8]  = '{169, 52, 1, 64, P(106,52), P(107,52), P(108,52), P(109,52), P(169,52), 0};
        vecs[9]  = '{105, 117, 1, 1, P(105,117), 0, 0, 0, P(105,117), 1};
        vecs[10] = '{639, 479, 1, 1, P(639,479), 0, 0, 0, P(639,479), 1};
        vecs[11] = '{640, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        vecs[12] = '{0, 480, 1, 0, 0, 0, 0, 0, 0, 0};
        vecs[13] = '{639, 479, 1, 1, P(639,479), 0, 0, 0, P(639,479), 1};
        vecs[14] = '{636, 476, 1, 3, P(638,478), P(637,477), P(636,476), 0, P(636,476), 0};
        vecs[15] = '{635, 470, 1, 6, P(636,475), P(636,474), P(636,473), P(635,472), P(635,470), 0};
        vecs[16] = '{10, 10, 1, 1, P(10,10), 0, 0, 0, P(10,10), 1};

        Reset        = 1'b1;
        sample_valid = 1'b0;
        sample_x     = '0;
        sample_y     = '0;
        pen_down     = 1'b0;
        wr_ready     = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_wr_valid", int'(wr_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_stroke_start", int'(stroke_start), 0);
        chk("reset_drop_count", int'(drop_count), 0);
        chk("reset_wr_xy", P(int'(wr_x), int'(wr_y)), P(0,0));
        Reset = 1'b0;
        @(posedge Clk); #1;

        // Table: one sample per vector, wr_ready held high.
        for (int vi = 0; vi < 17; vi++) begin
            v = vecs[vi];
            send(v.x, v.y, v.pen);
            collect(200, to);
            n = cap_px.size();
            $display("vec %0d: sample (%0d,%0d) pen=%0d -> %0d writes (expect %0d)",
                     vi, v.x, v.y, v.pen, n, v.n);
            chk($sformatf("vec%0d_timeout", vi), to, 0);
            chk($sformatf("vec%0d_count", vi), n, v.n);
            if (n == v.n && n > 0) begin
                chk($sformatf("vec%0d_latency", vi), cap_off[0], 1);
                chk($sformatf("vec%0d_rate", vi), cap_off[n-1], n);
                chk($sformatf("vec%0d_px0", vi), cap_px[0], v.p0);
                if (n > 1) chk($sformatf("vec%0d_px1", vi), cap_px[1], v.p1);
                if (n > 2) chk($sformatf("vec%0d_px2", vi), cap_px[2], v.p2);
                if (n > 3) chk($sformatf("vec%0d_px3", vi), cap_px[3], v.p3);
                chk($sformatf("vec%0d_last", vi), cap_px[n-1], v.last);
                chk($sformatf("vec%0d_ss_first", vi), cap_ss[0], int'(v.ss));
                if (n > 1) chk($sformatf("vec%0d_ss_second", vi), cap_ss[1], 0);
            end
        end

        // Stall mid-line: anchor (10,10) -> (10,7).
        send(10, 7, 1);
        @(posedge Clk); #1;
        chk("stall_valid0", int'(wr_valid), 1);
        chk("stall_px0", P(int'(wr_x), int'(wr_y)), P(10,9));
        @(posedge Clk); #1;
        chk("stall_px1", P(int'(wr_x), int'(wr_y)), P(10,8));
        wr_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(posedge Clk); #1;
            chk($sformatf("stall_hold_valid%0d", s), int'(wr_valid), 1);
            chk($sformatf("stall_hold_px%0d", s), P(int'(wr_x), int'(wr_y)), P(10,8));
        end
        wr_ready = 1'b1;
        @(posedge Clk); #1;
        chk("stall_px2", P(int'(wr_x), int'(wr_y)), P(10,7));
        @(posedge Clk); #1;
        chk("stall_end_busy", int'(busy), 0);
        chk("stall_end_valid", int'(wr_valid), 0);
        $display("seq stall: line (10,10)->(10,7) with 5-cycle stall");

        // Pending: long line (10,7)->(74,7), two more samples during it.
        chk("pend_drop_before", int'(drop_count), 0);
        send(74, 7, 1);
        fork
            collect(400, to);
            begin
                repeat (5) @(posedge Clk);
                #1;
                send(20, 20, 1);
                repeat (5) @(posedge Clk);
                #1;
                send(76, 8, 1);
            end
        join
        n = cap_px.size();
        $display("seq pending: %0d writes, drop_count=%0d", n, drop_count);
        chk("pend_timeout", to, 0);
        chk("pend_drop_count", int'(drop_count), 1);
        chk("pend_count", n, 66);
        if (n == 66) begin
            chk("pend_first", cap_px[0], P(11,7));
            chk("pend_line_end", cap_px[63], P(74,7));
            chk("pend_next0", cap_px[64], P(75,7));
            chk("pend_next1", cap_px[65], P(76,8));
            chk("pend_next_ss", cap_ss[64], 0);
            chk("pend_setup_gap", cap_off[64], 66);
        end

        // Reset in the middle of a line.
        send(140, 8, 1);
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_pre_valid", int'(wr_valid), 1);
        Reset = 1'b1;
        @(posedge Clk); #1;
        chk("rst_wr_valid", int'(wr_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_drop", int'(drop_count), 0);
        Reset = 1'b0;
        @(posedge Clk); #1;
        send(80, 8, 1);
        collect(200, to);
        n = cap_px.size();
        $display("seq reset: post-reset sample (80,8) -> %0d writes", n);
        chk("rst_after_timeout", to, 0);
        chk("rst_after_count", n, 1);
        if (n == 1) begin
            chk("rst_after_px", cap_px[0], P(80,8));
            chk("rst_after_ss", cap_ss[0], 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
